// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared scoreboard entry, controller state and latency codes
package pipe_ctrl_pkg;
  localparam int SB_DST_W = 8;
  localparam int SB_LAT_W = 4;
  localparam logic [SB_LAT_W-1:0] LAT_ALU  = 4'd0;
  localparam logic [SB_LAT_W-1:0] LAT_LOAD = 4'd1;
  localparam logic [SB_LAT_W-1:0] LAT_EXT  = 4'd2;
  typedef enum logic [1:0] {RUN, FLUSH, DRAIN, HALTED} ctrl_state_t;
  typedef struct packed {
    logic                v;
    logic                we;
    logic [SB_DST_W-1:0] dst;
    logic [SB_LAT_W-1:0] lat;
  } sb_entry_t;
endpackage

// File: rtl/fwd_match.sv
// fwd_match: youngest-producer match of one source address against the scoreboard
module fwd_match
  import pipe_ctrl_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int ADDR_W = 5,
  parameter int SEL_W  = 2
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              re,
  input  sb_entry_t         sb [DEPTH],
  output logic              hit,
  output logic [SEL_W-1:0]  k,
  output logic              stall_req
);
  logic [SB_LAT_W-1:0] lat_k;
  // scan oldest to youngest so the youngest match overwrites; R0 never matches
  always_comb begin
    hit   = 1'b0;
    k     = '0;
    lat_k = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (re && addr != '0 && sb[i].v && sb[i].we && sb[i].dst == SB_DST_W'(addr)) begin
        hit   = 1'b1;
        k     = SEL_W'(i);
        lat_k = sb[i].lat;
      end
    stall_req = hit && (SB_LAT_W'(k) < lat_k);
  end
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: decode-stage bypass select, load-use stall, flush window and halt drain
module fwd_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_REGS    = 32,
  parameter int NUM_SRC     = 2,
  parameter int DEPTH       = 3,
  parameter int FLUSH_SLOTS = 2,
  parameter int LAT_W       = 2,
  localparam int ADDR_W     = $clog2(NUM_REGS),
  localparam int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_SRC*ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_re,
  input  logic [ADDR_W-1:0]         id_dst_addr,
  input  logic                      id_we,
  input  logic [LAT_W-1:0]          id_lat,
  input  logic                      id_hlt,
  input  logic                      flow_change,
  output logic                      stall_if_id,
  output logic                      bubble_id_ex,
  output logic                      flush_id,
  output logic [NUM_SRC*SEL_W-1:0]  byp_sel,
  output logic                      halted
);
  ctrl_state_t         state, state_n;
  sb_entry_t           sb [DEPTH];
  sb_entry_t           sb_in;
  logic [2:0]          flush_cnt, flush_cnt_n;
  logic [SEL_W-1:0]    drain_cnt, drain_cnt_n;
  logic [NUM_SRC-1:0]  hit, stall_req;
  logic [SEL_W-1:0]    k [NUM_SRC];
  logic                run_like, halt_go, lu_stall, adv;
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_match
    fwd_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .SEL_W(SEL_W)) u_match (
      .addr      (id_src_addr[s*ADDR_W +: ADDR_W]),
      .re        (id_src_re[s]),
      .sb        (sb),
      .hit       (hit[s]),
      .k         (k[s]),
      .stall_req (stall_req[s])
    );
  end
  // hazard outputs: flush beats halt beats load-use; drain and halted hold the front end
  always_comb begin
    run_like     = state == RUN || state == FLUSH;
    flush_id     = run_like && (flow_change || flush_cnt != '0);
    halt_go      = state == RUN && id_valid && id_hlt && !flush_id;
    lu_stall     = id_valid && |stall_req && !flush_id && !halt_go;
    stall_if_id  = state == DRAIN || state == HALTED || lu_stall;
    bubble_id_ex = flush_id || stall_if_id;
    adv          = id_valid && !bubble_id_ex;
    sb_in        = adv ? {1'b1, id_we, SB_DST_W'(id_dst_addr), SB_LAT_W'(id_lat)} : '0;
    halted       = state == HALTED;
  end
  // next state and counters; flow changes are ignored once a HLT is committed
  always_comb begin
    flush_cnt_n = !run_like ? flush_cnt : flow_change ? 3'(FLUSH_SLOTS - 1) :
                  flush_cnt != '0 ? flush_cnt - 3'd1 : flush_cnt;
    drain_cnt_n = halt_go ? SEL_W'(DEPTH - 1) :
                  (state == DRAIN && drain_cnt != '0) ? drain_cnt - SEL_W'(1) : drain_cnt;
    state_n     = (state == HALTED || (state == DRAIN && drain_cnt == '0)) ? HALTED :
                  (state == DRAIN || halt_go) ? DRAIN :
                  flush_cnt_n != '0 ? FLUSH : RUN;
  end
  // registers: FSM, counters, scoreboard shift and the bypass selects for the next EX
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= RUN;
      flush_cnt <= '0;
      drain_cnt <= '0;
      byp_sel   <= '0;
      for (int i = 0; i < DEPTH; i++) sb[i] <= '0;
    end else begin
      state     <= state_n;
      flush_cnt <= flush_cnt_n;
      drain_cnt <= drain_cnt_n;
      sb[0]     <= sb_in;
      for (int i = 1; i < DEPTH; i++) sb[i] <= sb[i-1];
      for (int s = 0; s < NUM_SRC; s++)
        byp_sel[s*SEL_W +: SEL_W] <= (adv && hit[s]) ? k[s] + SEL_W'(1) : '0;
    end
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed scoreboard bench for the decode hazard controller
module tb_fwd_hazard_ctrl;
  import pipe_ctrl_pkg::*;
  logic       clk, rst;
  logic       id_valid, id_we, id_hlt, flow_change;
  logic [9:0] id_src_addr;
  logic [1:0] id_src_re;
  logic [4:0] id_dst_addr;
  logic [1:0] id_lat;
  logic       stall_if_id, bubble_id_ex, flush_id, halted;
  logic [3:0] byp_sel;
  logic [3:0] exp_q [$];
  int         n_vec, n_err, step_no;
  fwd_hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_src_addr  (id_src_addr),
    .id_src_re    (id_src_re),
    .id_dst_addr  (id_dst_addr),
    .id_we        (id_we),
    .id_lat       (id_lat),
    .id_hlt       (id_hlt),
    .flow_change  (flow_change),
    .stall_if_id  (stall_if_id),
    .bubble_id_ex (bubble_id_ex),
    .flush_id     (flush_id),
    .byp_sel      (byp_sel),
    .halted       (halted)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL step %0d %s: got %0h expected %0h", step_no, tag, obs, exp);
    end
  endtask
  task automatic drv(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                     input logic [1:0] re, input logic [4:0] dst, input logic we,
                     input logic [1:0] lat, input logic hlt, input logic fc);
    id_valid    = v;
    id_src_addr = {s1, s0};
    id_src_re   = re;
    id_dst_addr = dst;
    id_we       = we;
    id_lat      = lat;
    id_hlt      = hlt;
    flow_change = fc;
  endtask
  task automatic idle();
    drv(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask
  // one clock: check hazard outputs mid-cycle, queue the select expected after the edge
  task automatic cyc(input logic es, input logic eb, input logic ef, input logic eh,
                     input logic [3:0] ebyp);
    step_no++;
    @(negedge clk);
    chk("stall_if_id", stall_if_id, es);
    chk("bubble_id_ex", bubble_id_ex, eb);
    chk("flush_id", flush_id, ef);
    chk("halted", halted, eh);
    exp_q.push_back(ebyp);
    @(posedge clk);
    #1;
    chk("byp_sel", byp_sel, exp_q.pop_front());
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, " stall"}, stall_if_id, 1'b0);
    chk({tag, " bubble"}, bubble_id_ex, 1'b0);
    chk({tag, " flush"}, flush_id, 1'b0);
    chk({tag, " halted"}, halted, 1'b0);
    chk({tag, " byp_sel"}, byp_sel, 4'h0);
  endtask
  initial begin
    logic [1:0] alu, ld, ext;
    alu = LAT_ALU[1:0];
    ld  = LAT_LOAD[1:0];
    ext = LAT_EXT[1:0];
    n_vec = 0; n_err = 0; step_no = 0;
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_idle_outputs("reset");
    // ALU -> ALU on port 1: no stall, result one stage past EX
    drv(1, 0, 0, 2'b00, 3, 1, alu, 0, 0); cyc(0, 0, 0, 0, 4'h0);
    drv(1, 0, 3, 2'b10, 0, 0, alu, 0, 0); cyc(0, 0, 0, 0, 4'h4);
    // load-use on port 0: one stall cycle, then forward from two stages past EX
    drv(1, 0, 0, 2'b00, 5, 1, ld, 0, 0);  cyc(0, 0, 0, 0, 4'h0);
    drv(1, 5, 0, 2'b01, 0, 0, alu, 0, 0); cyc(1, 1, 0, 0, 4'h0);
    cyc(0, 0, 0, 0, 4'h2);
    // R0 is never bypassed
    drv(1, 0, 0, 2'b00, 0, 1, alu, 0, 0); cyc(0, 0, 0, 0, 4'h0);
    drv(1, 0, 0, 2'b11, 0, 0, alu, 0, 0); cyc(0, 0, 0, 0, 4'h0);
    // R7 written twice: youngest producer wins
    drv(1, 0, 0, 2'b00, 7, 1, alu, 0, 0);  cyc(0, 0, 0, 0, 4'h0);
    drv(1, 0, 0, 2'b00, 10, 1, alu, 0, 0); cyc(0, 0, 0, 0, 4'h0);
    drv(1, 0, 0, 2'b00, 7, 1, alu, 0, 0);  cyc(0, 0, 0, 0, 4'h0);
    drv(1, 7, 0, 2'b01, 0, 0, alu, 0, 0);  cyc(0, 0, 0, 0, 4'h1);
    // extended latency: two stalls, then select 3 on port 1
    drv(1, 0, 0, 2'b00, 9, 1, ext, 0, 0); cyc(0, 0, 0, 0, 4'h0);
    drv(1, 0, 9, 2'b10, 0, 0, alu, 0, 0); cyc(1, 1, 0, 0, 4'h0);
    cyc(1, 1, 0, 0, 4'h0);
    cyc(0, 0, 0, 0, 4'hC);
    // flush window: two killed slots, load-use suppressed, killed writers never tracked
    drv(1, 0, 0, 2'b00, 6, 1, ext, 0, 0);  cyc(0, 0, 0, 0, 4'h0);
    drv(1, 0, 0, 2'b00, 12, 1, alu, 0, 1); cyc(0, 1, 1, 0, 4'h0);
    drv(1, 6, 0, 2'b01, 12, 1, alu, 0, 0); cyc(0, 1, 1, 0, 4'h0);
    drv(1, 6, 12, 2'b11, 0, 0, alu, 0, 0); cyc(0, 0, 0, 0, 4'h3);
    // back-to-back flow changes reload the window
    drv(0, 0, 0, 2'b00, 0, 0, alu, 0, 1); cyc(0, 1, 1, 0, 4'h0);
    cyc(0, 1, 1, 0, 4'h0);
    idle(); cyc(0, 1, 1, 0, 4'h0);
    cyc(0, 0, 0, 0, 4'h0);
    // halt: three drain cycles, flow changes ignored, then sticky halted
    drv(1, 0, 0, 2'b00, 0, 0, alu, 1, 0); cyc(0, 0, 0, 0, 4'h0);
    idle(); cyc(1, 1, 0, 0, 4'h0);
    drv(0, 0, 0, 2'b00, 0, 0, alu, 0, 1); cyc(1, 1, 0, 0, 4'h0);
    idle(); cyc(1, 1, 0, 0, 4'h0);
    cyc(1, 1, 0, 1, 4'h0);
    drv(0, 0, 0, 2'b00, 0, 0, alu, 0, 1); cyc(1, 1, 0, 1, 4'h0);
    idle(); cyc(1, 1, 0, 1, 4'h0);
    // asynchronous reset out of HALTED
    rst = 1'b1;
    #2 chk_idle_outputs("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    chk_idle_outputs("post_rst");
    drv(1, 0, 0, 2'b00, 4, 1, alu, 0, 0); cyc(0, 0, 0, 0, 4'h0);
    drv(1, 4, 0, 2'b01, 0, 0, alu, 0, 0); cyc(0, 0, 0, 0, 4'h1);
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
